// File: rtl/sm_input_debounce.sv
// Pin conditioning: two-flop synchroniser, per-bit debounce with rise/fall pulses,
// and a sticky rise-event mask with ack. Optional toggle output: SM_INPUT_DEBOUNCE_TOGGLE_EN.
module sm_input_debounce #(
    parameter int               WIDTH         = 8,
    parameter int               CNT_W         = 16,
    parameter int               STABLE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] out_level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_mask,
    input  logic             evt_ack
`ifdef SM_INPUT_DEBOUNCE_TOGGLE_EN
    ,
    output logic [WIDTH-1:0] toggle
`endif
);

    typedef enum logic {
        DEB_STABLE  = 1'b0,
        DEB_PENDING = 1'b1
    } deb_state_e;

    // Count value on whose differing edge the new level is accepted.
    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] mask_snapshot;
    logic [WIDTH-1:0] accept_vec;

    always_comb begin
        sync1_d = in_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        deb_state_e       state;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             accept;

        always_comb begin
            state  = (sync2_q[gi] != level_q[gi]) ? DEB_PENDING : DEB_STABLE;
            accept = 1'b0;
            cnt_d  = '0;
            case (state)
                DEB_STABLE: begin
                    // Any agreeing sample (including a bounce back) discards progress.
                    cnt_d = '0;
                end
                DEB_PENDING: begin
                    if (cnt_q == ACCEPT_CNT) begin
                        accept = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign accept_vec[gi] = accept;
    end

    always_comb begin
        level_d = (level_q & ~accept_vec) | (sync2_q & accept_vec);
        rise_d  = accept_vec & sync2_q;
        fall_d  = accept_vec & ~sync2_q;
    end

    // The snapshot is exactly what the consumer sees this cycle, so an ack clears
    // only those bits; a rise landing in the same cycle survives via the OR.
    always_comb begin
        mask_snapshot = mask_q;
        if (evt_ack) begin
            mask_d = (mask_q & ~mask_snapshot) | rise_q;
        end else begin
            mask_d = mask_q | rise_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= RESET_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
            mask_q  <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            mask_q  <= mask_d;
        end
    end

    assign out_level = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign evt_mask  = mask_q;
    assign evt_valid = |mask_q;

`ifdef SM_INPUT_DEBOUNCE_TOGGLE_EN
    logic [WIDTH-1:0] toggle_q, toggle_d;

    // Flips in the same edge that raises the rise pulse.
    always_comb begin
        toggle_d = toggle_q ^ rise_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_q <= '0;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign toggle = toggle_q;
`endif

endmodule

// File: tb/tb_sm_input_debounce.sv
// Directed bench for sm_input_debounce with STABLE_CYCLES=4, WIDTH=8.
module tb_sm_input_debounce;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_raw;
    logic [7:0] out_level;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       evt_valid;
    logic [7:0] evt_mask;
    logic       evt_ack;
`ifdef SM_INPUT_DEBOUNCE_TOGGLE_EN
    logic [7:0] toggle;
`endif

    int checks = 0;
    int errors = 0;
    int fall1_cnt;
    logic [7:0] bounce_seq;

    sm_input_debounce #(
        .WIDTH        (8),
        .CNT_W        (16),
        .STABLE_CYCLES(4),
        .RESET_LEVEL  (8'hFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_raw   (in_raw),
        .out_level(out_level),
        .rise     (rise),
        .fall     (fall),
        .evt_valid(evt_valid),
        .evt_mask (evt_mask),
        .evt_ack  (evt_ack)
`ifdef SM_INPUT_DEBOUNCE_TOGGLE_EN
        ,
        .toggle   (toggle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        in_raw  = 8'hFF;
        evt_ack = 1'b0;
        tick();
        tick();

        // Asynchronous reset asserted between edges.
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_level", 32'(out_level), 32'h0000_00FF);
        chk("rst_rise", 32'(rise), 32'h0);
        chk("rst_fall", 32'(fall), 32'h0);
        chk("rst_mask", 32'(evt_mask), 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        $display("reset: level=%h rise=%h fall=%h mask=%h valid=%b",
                 out_level, rise, fall, evt_mask, evt_valid);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Clean press on bit 0: change before E0, accepted at E0+5.
        in_raw = 8'hFE;
        repeat (5) tick();                   // after E0+4
        chk("press_early_level", 32'(out_level), 32'h0000_00FF);
        chk("press_early_fall", 32'(fall), 32'h0);
        tick();                              // after E0+5
        chk("press_level", 32'(out_level), 32'h0000_00FE);
        chk("press_fall", 32'(fall), 32'h0000_0001);
        chk("press_rise", 32'(rise), 32'h0);
        tick();                              // after E0+6
        chk("press_fall_clr", 32'(fall), 32'h0);
        chk("press_mask", 32'(evt_mask), 32'h0);
        $display("press: level=%h fall=%h mask=%h", out_level, fall, evt_mask);

        // Bounce on bit 1: 1,0,0,1,0,0,0,0; the final run starts before E0+4 -> accept at E0+9.
        bounce_seq = 8'b0000_1001;           // bit c = sample for cycle c
        fall1_cnt  = 0;
        for (int c = 0; c < 8; c++) begin
            in_raw[1] = bounce_seq[c];
            tick();                          // after E0+c
            if (fall[1]) fall1_cnt++;
            if (c == 6) chk("bounce_no_early_e6", 32'(out_level), 32'h0000_00FE);
        end
        tick();                              // after E0+8
        if (fall[1]) fall1_cnt++;
        chk("bounce_level_e8", 32'(out_level), 32'h0000_00FE);
        chk("bounce_pulses_e8", 32'(fall1_cnt), 32'd0);
        tick();                              // after E0+9
        if (fall[1]) fall1_cnt++;
        chk("bounce_level_e9", 32'(out_level), 32'h0000_00FC);
        chk("bounce_fall_e9", 32'(fall), 32'h0000_0002);
        tick();
        if (fall[1]) fall1_cnt++;
        chk("bounce_pulses", 32'(fall1_cnt), 32'd1);
        $display("bounce: level=%h fall_pulses=%0d", out_level, fall1_cnt);

        // Release bit 0: rise pulse, then sticky mask.
        in_raw = 8'hFD;
        repeat (5) tick();                   // after E0+4
        chk("rel_early_rise", 32'(rise), 32'h0);
        tick();                              // after E0+5
        chk("rel_level", 32'(out_level), 32'h0000_00FD);
        chk("rel_rise", 32'(rise), 32'h0000_0001);
        chk("rel_fall", 32'(fall), 32'h0);
        tick();                              // after E0+6
        chk("rel_rise_clr", 32'(rise), 32'h0);
        chk("rel_mask", 32'(evt_mask), 32'h0000_0001);
        chk("rel_valid", 32'(evt_valid), 32'h1);
        repeat (20) tick();
        chk("rel_mask_hold", 32'(evt_mask), 32'h0000_0001);
        chk("rel_valid_hold", 32'(evt_valid), 32'h1);
        $display("release: level=%h mask=%h valid=%b", out_level, evt_mask, evt_valid);

        // Take bit 2 low first, then raise it so its rise coincides with an ack.
        in_raw = 8'hF9;
        repeat (8) tick();
        chk("ack_prep_level", 32'(out_level), 32'h0000_00F9);
        chk("ack_prep_mask", 32'(evt_mask), 32'h0000_0001);
        in_raw = 8'hFD;
        repeat (6) tick();                   // after E0+5: rise[2] visible
        chk("ack_rise2", 32'(rise), 32'h0000_0004);
        chk("ack_mask_before", 32'(evt_mask), 32'h0000_0001);
        evt_ack = 1'b1;
        tick();
        chk("ack_race_mask", 32'(evt_mask), 32'h0000_0004);
        chk("ack_race_valid", 32'(evt_valid), 32'h1);
        evt_ack = 1'b0;
        tick();
        chk("ack_mask_hold", 32'(evt_mask), 32'h0000_0004);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("ack_clear_mask", 32'(evt_mask), 32'h0);
        chk("ack_clear_valid", 32'(evt_valid), 32'h0);
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
        chk("ack_empty_mask", 32'(evt_mask), 32'h0);
        $display("ack: mask=%h valid=%b", evt_mask, evt_valid);

        // Reset mid-debounce on bit 3; bit 1 (still low at the pin) restarts too.
        in_raw = 8'hF5;
        repeat (4) tick();                   // two differing samples counted
        chk("mid_pre_level", 32'(out_level), 32'h0000_00FD);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(out_level), 32'h0000_00FF);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();                   // after R5
        chk("mid_no_early_fall", 32'(fall), 32'h0);
        chk("mid_no_early_level", 32'(out_level), 32'h0000_00FF);
        tick();                              // after R6
        chk("mid_fall", 32'(fall), 32'h0000_000A);
        chk("mid_level", 32'(out_level), 32'h0000_00F5);
        tick();
        chk("mid_fall_clr", 32'(fall), 32'h0);
        chk("mid_mask", 32'(evt_mask), 32'h0);
        $display("mid-reset: level=%h fall_cleared=%h mask=%h", out_level, fall, evt_mask);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
